huffman_encoder: RTL and testbench

- Producer-side counterpart of the team's 4-bit-symbol Huffman decoder.
- Accepts 32-bit words of eight 4-bit symbols, encodes each symbol with the shared prefix-code table, and packs the codes MSB-first into fixed-width output words with valid/ready handshakes.
- Sits between the symbol source (e.g. the weight/activation compressor) and the compressed-stream buffer that feeds the decoder.

---
 rtl/huffman_encoder.sv | 182 ++++++++++++++++++
 tb/tb_huffman_encoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_encoder.sv
// huffman_encoder: packs 4-bit symbols into MSB-first prefix codes and emits
// fixed-width OUT_W-bit words over a valid/ready stream.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_data/in_valid/in_last    NSYM symbols per word, symbol 0 in the top nibble
//   in_ready                    high only while idle
//   out_data/out_valid/out_ready packed code bits, MSB = earliest bit
//   out_last                    final output word of a stream
//   out_nbits                   meaningful left-justified bits in out_data
//   sym_err                     one-cycle pulse when an unmapped symbol is dropped
//   total_bits                  appended code-bit counter
//
// Build option: define HENC_STATS_EN to build the total_bits counter;
// otherwise total_bits is tied to zero.
module huffman_encoder #(
  parameter int unsigned OUT_W = 16,
  parameter int unsigned NSYM  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4*NSYM-1:0]            in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [$clog2(OUT_W+1)-1:0]   out_nbits,
  output logic                         sym_err,
  output logic [31:0]                  total_bits
);

  localparam int unsigned IN_W  = 4 * NSYM;
  localparam int unsigned ACC_W = OUT_W + 6;
  localparam int unsigned CNT_W = $clog2(ACC_W);
  localparam int unsigned IDX_W = $clog2(NSYM + 1);
  localparam int unsigned NB_W  = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_EMIT, S_FLUSH} state_t;

  state_t             state;
  logic [IN_W-1:0]    word;
  logic [IDX_W-1:0]   idx;
  logic               last_flag;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;

  logic [3:0]         cur_sym_c;
  logic [2:0]         cur_len_c;
  logic [5:0]         cur_code_c;
  logic [ACC_W-1:0]   code_ext_c;
  logic               do_emit_c;
  logic               take_sym_c;

  // Code table: {length, code left-justified in 6 bits}; length 0 = unmapped.
  function automatic logic [8:0] code_lookup(input logic [3:0] s);
    case (s)
      4'd0:    return {3'd1, 6'b100000};
      4'd1:    return {3'd4, 6'b010000};
      4'd2:    return {3'd4, 6'b010100};
      4'd3:    return {3'd6, 6'b011000};
      4'd4:    return {3'd6, 6'b011001};
      4'd5:    return {3'd4, 6'b001000};
      4'd6:    return {3'd4, 6'b001100};
      4'd7:    return {3'd5, 6'b011010};
      4'd8:    return {3'd6, 6'b000110};
      4'd9:    return {3'd4, 6'b011100};
      4'd10:   return {3'd4, 6'b000000};
      4'd12:   return {3'd6, 6'b000111};
      4'd14:   return {3'd6, 6'b000100};
      4'd15:   return {3'd6, 6'b000101};
      default: return {3'd0, 6'b000000};
    endcase
  endfunction

  // Current symbol is always the top nibble of the shifting word register;
  // its code is aligned just below the cnt valid bits of the accumulator.
  always_comb begin
    cur_sym_c               = word[IN_W-1 -: 4];
    {cur_len_c, cur_code_c} = code_lookup(cur_sym_c);
    code_ext_c              = ACC_W'({cur_code_c, {(ACC_W-6){1'b0}}} >> cnt);
    do_emit_c               = (cnt >= CNT_W'(OUT_W));
    take_sym_c              = (state == S_ENCODE) && !do_emit_c && (idx < IDX_W'(NSYM));
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      word      <= '0;
      idx       <= '0;
      last_flag <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_nbits <= '0;
      sym_err   <= 1'b0;
    end else begin
      sym_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            word      <= in_data;
            last_flag <= in_last;
            idx       <= '0;
            in_ready  <= 1'b0;
            state     <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          if (do_emit_c) begin
            state     <= S_EMIT;
            out_valid <= 1'b1;
            out_data  <= acc[ACC_W-1 -: OUT_W];
            out_nbits <= NB_W'(OUT_W);
            out_last  <= last_flag && (idx == IDX_W'(NSYM)) && (cnt == CNT_W'(OUT_W));
          end else if (take_sym_c) begin
            acc  <= acc | code_ext_c;
            cnt  <= cnt + CNT_W'(cur_len_c);
            idx  <= idx + IDX_W'(1);
            word <= word << 4;
            if (cur_len_c == 3'd0) sym_err <= 1'b1;
          end else if (last_flag && (cnt != '0)) begin
            state     <= S_FLUSH;
            out_valid <= 1'b1;
            out_data  <= acc[ACC_W-1 -: OUT_W];
            out_nbits <= NB_W'(cnt);
            out_last  <= 1'b1;
          end else begin
            // Residual bits stay in acc and continue with the next word.
            last_flag <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            acc       <= acc << OUT_W;
            cnt       <= cnt - CNT_W'(OUT_W);
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              last_flag <= 1'b0;
              in_ready  <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_ENCODE;
            end
          end
        end
        S_FLUSH: begin
          if (out_ready) begin
            acc       <= '0;
            cnt       <= '0;
            last_flag <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HENC_STATS_EN
  // Running count of appended code bits, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst)             total_bits <= '0;
    else if (take_sym_c) total_bits <= total_bits + 32'(cur_len_c);
  end
`else
  assign total_bits = '0;
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Scoreboard bench for huffman_encoder: stimulus pushes expected output words,
// a negedge monitor pops and compares on every handshake.
module tb_huffman_encoder;

  localparam int unsigned OUT_W = 16;
  localparam int unsigned NSYM  = 8;
  localparam int unsigned NB_W  = $clog2(OUT_W + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [4*NSYM-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  logic [NB_W-1:0]   out_nbits;
  logic              sym_err;
  logic [31:0]       total_bits;

  always #5 clk = ~clk;

  huffman_encoder #(.OUT_W(OUT_W), .NSYM(NSYM)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_nbits  (out_nbits),
    .sym_err    (sym_err),
    .total_bits (total_bits)
  );

  typedef struct {
    logic [OUT_W-1:0] data;
    int               nbits;
    bit               last;
  } exp_t;

  exp_t        exp_q[$];
  bit          pend[$];
  int          code_len[16];
  int          code_val[16];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          err_seen = 0;
  int          exp_err = 0;
  logic [31:0] exp_bits = '0;
  int          bp_mode = 0;

  // Monitor state
  exp_t             e;
  bit               stall = 0;
  logic [OUT_W-1:0] prev_data;
  logic [NB_W-1:0]  prev_nb;
  logic             prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [OUT_W-1:0] d, input int nb, input bit l);
    exp_t t;
    t.data = d; t.nbits = nb; t.last = l;
    exp_q.push_back(t);
  endtask

  // Reference model: a plain bit queue, emitting whole words as they fill.
  task automatic model_word(input logic [31:0] w, input bit l);
    logic [3:0]       s;
    logic [OUT_W-1:0] d;
    int               len, n;
    for (int j = 0; j < NSYM; j++) begin
      s   = w[31-4*j -: 4];
      len = code_len[s];
      if (len == 0) exp_err++;
      for (int b = len - 1; b >= 0; b--) pend.push_back(code_val[s][b]);
      exp_bits += 32'(len);
      if (pend.size() >= OUT_W) begin
        bit lst;
        lst = l && (j == NSYM - 1) && (pend.size() == OUT_W);
        d = '0;
        for (int k = 0; k < OUT_W; k++) d = (d << 1) | OUT_W'(pend.pop_front());
        push_exp(d, OUT_W, lst);
      end
    end
    if (l && pend.size() > 0) begin
      n = pend.size();
      d = '0;
      for (int k = 0; k < OUT_W; k++) d = (d << 1) | OUT_W'((k < n) ? pend.pop_front() : 1'b0);
      push_exp(d, n, 1'b1);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input bit l);
    int cyc = 0;
    while (!in_ready && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 2000) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout in_ready=%0b", in_ready);
    end
    in_data = d; in_last = l; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || !in_ready) && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 3000) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout pending=%0d in_ready=%0b", name, exp_q.size(), in_ready);
      exp_q.delete();
    end
    chk({name, "_symerr"}, 32'(err_seen), 32'(exp_err));
`ifdef HENC_STATS_EN
    chk({name, "_bits"}, total_bits, exp_bits);
`else
    chk({name, "_bits"}, total_bits, 32'd0);
`endif
  endtask

  task automatic check_reset(input string name);
    chk({name, "_in_ready"},   32'(in_ready),   32'd1);
    chk({name, "_out_valid"},  32'(out_valid),  32'd0);
    chk({name, "_out_last"},   32'(out_last),   32'd0);
    chk({name, "_sym_err"},    32'(sym_err),    32'd0);
    chk({name, "_out_data"},   32'(out_data),   32'd0);
    chk({name, "_out_nbits"},  32'(out_nbits),  32'd0);
    chk({name, "_total_bits"}, total_bits,      32'd0);
  endtask

  // Sink backpressure: 0 = always ready, 1 = random, 2 = held off.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: stability under backpressure, sym_err pulses, output scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      stall = 0;
    end else begin
      if (stall) begin
        n_cmp++;
        if (!out_valid || out_data !== prev_data || out_nbits !== prev_nb || out_last !== prev_last) begin
          n_fail++;
          $display("FAIL stable got valid=%0b data=%h nbits=%0d last=%0b expected valid=1 data=%h nbits=%0d last=%0b",
                   out_valid, out_data, out_nbits, out_last, prev_data, prev_nb, prev_last);
        end
      end
      if (sym_err) err_seen++;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word got data=%h nbits=%0d last=%0b expected none", out_data, out_nbits, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_nbits !== NB_W'(e.nbits) || out_last !== e.last) begin
            n_fail++;
            $display("FAIL out_word got data=%h nbits=%0d last=%0b expected data=%h nbits=%0d last=%0b",
                     out_data, out_nbits, out_last, e.data, e.nbits, e.last);
          end
        end
      end
      stall     = out_valid && !out_ready;
      prev_data = out_data;
      prev_nb   = out_nbits;
      prev_last = out_last;
    end
  end

  initial begin
    int cyc;
    int nw;
    logic [31:0] d;
    bit l;

    code_len = '{1, 4, 4, 6, 6, 4, 4, 5, 6, 4, 4, 0, 6, 0, 6, 6};
    code_val = '{'b1, 'b0100, 'b0101, 'b011000, 'b011001, 'b0010, 'b0011, 'b01101,
                 'b000110, 'b0111, 'b0000, 0, 'b000111, 0, 'b000100, 'b000101};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // All zeros: eight single-bit codes, flushed.
    push_exp(16'hFF00, 8, 1'b1);
    exp_bits += 32'd8;
    send_word(32'h00000000, 1'b1);
    drain("zeros");

    // Exactly two full words, no flush.
    push_exp(16'h7777, 16, 1'b0);
    push_exp(16'h7777, 16, 1'b1);
    exp_bits += 32'd32;
    send_word(32'h99999999, 1'b1);
    drain("nines");

    // Six-bit code followed by seven ones.
    push_exp(16'h63F8, 13, 1'b1);
    exp_bits += 32'd13;
    send_word(32'h30000000, 1'b1);
    drain("three");

    // Unmapped symbol dropped with one sym_err pulse.
    push_exp(16'hFE00, 7, 1'b1);
    exp_bits += 32'd7;
    exp_err++;
    send_word(32'hB0000000, 1'b1);
    drain("unmapped");

    // Backpressure across an EMIT.
    bp_mode = 2;
    push_exp(16'h7777, 16, 1'b0);
    push_exp(16'h7777, 16, 1'b1);
    exp_bits += 32'd32;
    send_word(32'h99999999, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    bp_mode = 0;
    drain("backpressure");

    // Residual-free two-word stream ending in a flush.
    push_exp(16'h4444, 16, 1'b0);
    push_exp(16'h4444, 16, 1'b0);
    push_exp(16'hFF00, 8, 1'b1);
    exp_bits += 32'd40;
    send_word(32'h11111111, 1'b0);
    send_word(32'h00000000, 1'b1);
    drain("two_word");

    // Same stream, reset while the second word is being encoded.
    push_exp(16'h4444, 16, 1'b0);
    push_exp(16'h4444, 16, 1'b0);
    exp_bits += 32'd32;
    send_word(32'h11111111, 1'b0);
    drain("pre_reset");
    send_word(32'h00000000, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("mid_reset");
    rst = 1'b0;
    exp_bits = '0;
    exp_q.delete();
    pend.delete();

    // Randomized streams against the bit-queue model.
    bp_mode = 1;
    for (int s = 0; s < 8; s++) begin
      nw = $urandom_range(6, 1);
      for (int w = 0; w < nw; w++) begin
        d = $urandom;
        l = (w == nw - 1) || ($urandom_range(3) == 0);
        model_word(d, l);
        send_word(d, l);
      end
      drain("random");
    end
    bp_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
